// File: rtl/loader_pkg.sv
// Shared loader state type, byte width and default terminator helper.
// Latency: none (types and constants only). Backpressure: not applicable.
package loader_pkg;

    localparam int BYTE_W     = 8;
    localparam int MAX_DATA_W = 1024;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        CSUM,
        DONE
    } state_t;

    // All-ones pattern of data_w bits, zero-extended to MAX_DATA_W.
    function automatic logic [MAX_DATA_W-1:0] default_terminator(input int data_w);
        logic [MAX_DATA_W-1:0] ones;
        ones = '0;
        for (int i = 0; i < MAX_DATA_W; i++) begin
            if (i < data_w) ones[i] = 1'b1;
        end
        return ones;
    endfunction

endpackage

// File: rtl/uart_byte_assembler.sv
// Packs bytes LSB first into a word and times out stalled partial words.
// Latency: word_vld is combinational with the final byte. Backpressure: none.
module uart_byte_assembler
    import loader_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 1_000_000
) (
    input  logic              i_clk,
    input  logic              i_resetn,
    input  logic              i_byte_vld,
    input  logic [BYTE_W-1:0] i_byte_dat,
    input  logic              i_clear,
    input  logic              i_timer_en,
    output logic              o_word_vld,
    output logic [DATA_W-1:0] o_word,
    output logic              o_timeout_pulse
);

    localparam int BPW    = DATA_W / BYTE_W;
    localparam int IDX_W  = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int TCNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [DATA_W-1:0] r_shift;
    logic [IDX_W-1:0]  r_idx;
    logic [TCNT_W-1:0] r_tcnt;
    logic              w_last;
    logic [DATA_W-1:0] w_word;

    assign w_last = (r_idx == IDX_W'(BPW - 1));

    always_comb begin
        w_word = r_shift;
        w_word[BYTE_W*int'(r_idx) +: BYTE_W] = i_byte_dat;
    end

    assign o_word_vld = i_byte_vld && w_last;
    assign o_word     = w_word;
    // An accepted byte in the expiry cycle takes priority over the timeout.
    assign o_timeout_pulse = i_timer_en && !i_byte_vld && (r_tcnt == TCNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_shift <= '0;
            r_idx   <= '0;
            r_tcnt  <= '0;
        end else if (i_clear || o_timeout_pulse) begin
            r_shift <= '0;
            r_idx   <= '0;
            r_tcnt  <= '0;
        end else if (i_byte_vld) begin
            r_shift <= w_last ? '0 : w_word;
            r_idx   <= w_last ? '0 : r_idx + 1'b1;
            r_tcnt  <= '0;
        end else if (i_timer_en) begin
            r_tcnt  <= r_tcnt + 1'b1;
        end else begin
            r_tcnt  <= '0;
        end
    end

endmodule

// File: rtl/uart_word_loader.sv
// UART program loader: bytes -> DATA_W words -> sequential memory writes; optional LOADER_CHECKSUM_EN.
// Latency: mem_we one cycle after the final byte strobe. Backpressure: none, bytes in DONE are dropped.
module uart_word_loader
    import loader_pkg::*;
#(
    parameter int                DATA_W      = 32,
    parameter int                DEPTH       = 256,
    parameter logic [DATA_W-1:0] TERMINATOR  = DATA_W'(default_terminator(DATA_W)),
    parameter int                TIMEOUT_CYC = 1_000_000,
    localparam int               ADDR_W      = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_resetn,
    input  logic              i_uart_rx_en,
    input  logic              i_uart_rx_valid,
    input  logic [7:0]        i_uart_rx_data,
    input  logic              i_uart_rx_break,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    output logic              o_write_done,
    output logic              o_overflow,
    output logic              o_timeout_err,
    output logic [ADDR_W:0]   o_word_count,
    output logic              o_checksum_ok
);

    state_t            r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [ADDR_W:0]   r_count;
    logic              r_mem_we;
    logic              r_done;
    logic              r_ovf;
    logic              r_to;
`ifdef LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] r_sum;
    logic              r_csum_ok;
`endif

    logic              w_accept;
    logic              w_timer_en;
    logic              w_word_vld;
    logic [DATA_W-1:0] w_word;
    logic              w_timeout;
    logic              w_full;

    // Break wins over a coincident byte strobe.
    assign w_accept   = i_uart_rx_en && i_uart_rx_valid && !i_uart_rx_break && (r_state != DONE);
    assign w_timer_en = (r_state == LOAD) || (r_state == CSUM);
    assign w_full     = (r_count == (ADDR_W+1)'(DEPTH));

    uart_byte_assembler #(
        .DATA_W      (DATA_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_asm (
        .i_clk           (i_clk),
        .i_resetn        (i_resetn),
        .i_byte_vld      (w_accept),
        .i_byte_dat      (i_uart_rx_data),
        .i_clear         (i_uart_rx_break),
        .i_timer_en      (w_timer_en),
        .o_word_vld      (w_word_vld),
        .o_word          (w_word),
        .o_timeout_pulse (w_timeout)
    );

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_state     <= IDLE;
            r_addr      <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_count     <= '0;
            r_mem_we    <= 1'b0;
            r_done      <= 1'b0;
            r_ovf       <= 1'b0;
            r_to        <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            r_sum       <= '0;
            r_csum_ok   <= 1'b1;
`endif
        end else begin
            r_mem_we <= 1'b0;
            if (i_uart_rx_break) begin
                r_state <= IDLE;
                r_addr  <= '0;
                r_count <= '0;
                r_done  <= 1'b0;
                r_ovf   <= 1'b0;
                r_to    <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
                r_sum     <= '0;
                r_csum_ok <= 1'b1;
`endif
            end else if (w_word_vld) begin
                if (r_state == CSUM) begin
`ifdef LOADER_CHECKSUM_EN
                    r_csum_ok <= (w_word == r_sum);
`endif
                    r_done  <= 1'b1;
                    r_state <= DONE;
                end else if (w_word == TERMINATOR) begin
`ifdef LOADER_CHECKSUM_EN
                    r_state <= CSUM;
`else
                    r_done  <= 1'b1;
                    r_state <= DONE;
`endif
                end else if (w_full) begin
                    r_ovf   <= 1'b1;
                    r_done  <= 1'b1;
                    r_state <= DONE;
                end else begin
                    r_mem_we    <= 1'b1;
                    r_mem_addr  <= r_addr;
                    r_mem_wdata <= w_word;
                    r_addr      <= (r_addr == ADDR_W'(DEPTH - 1)) ? r_addr : r_addr + 1'b1;
                    r_count     <= r_count + 1'b1;
                    r_state     <= IDLE;
`ifdef LOADER_CHECKSUM_EN
                    r_sum       <= r_sum + w_word;
`endif
                end
            end else if (w_timeout) begin
                r_to <= 1'b1;
                if (r_state == CSUM) begin
`ifdef LOADER_CHECKSUM_EN
                    r_csum_ok <= 1'b0;
`endif
                    r_done  <= 1'b1;
                    r_state <= DONE;
                end else begin
                    r_state <= IDLE;
                end
            end else if (w_accept && (r_state == IDLE)) begin
                r_state <= LOAD;
            end
        end
    end

    assign o_mem_we      = r_mem_we;
    assign o_mem_addr    = r_mem_addr;
    assign o_mem_wdata   = r_mem_wdata;
    assign o_write_done  = r_done;
    assign o_overflow    = r_ovf;
    assign o_timeout_err = r_to;
    assign o_word_count  = r_count;
`ifdef LOADER_CHECKSUM_EN
    assign o_checksum_ok = r_csum_ok;
`else
    assign o_checksum_ok = 1'b1;
`endif

endmodule

// File: doc/uart_word_loader.md
Name: uart_word_loader

Overview:
- Parametrised successor to the fixed 32-bit UART instruction loader that sits between the UART receiver and instruction memory in the wrapper.
- Assembles received bytes, LSB first, into DATA_W-bit words and writes them to sequential memory addresses.
- Stops on a terminator word and raises write_done.
- Adds behaviour the fixed loader lacks: depth overflow detection, inter-byte timeout resync, and BREAK-triggered restart.

Parameters:
- DATA_W, 32, word width in bits; must be a multiple of 8.
- DEPTH, 256, number of memory words; ADDR_W = $clog2(DEPTH).
- TERMINATOR, all-ones of DATA_W, end-of-program word; it is never written to memory.
- TIMEOUT_CYC, 1_000_000, idle clocks allowed between bytes of a partial word before it is discarded.

Ports:
- clk  in  1  system clock.
- resetn  in  1  asynchronous active-low reset.
- uart_rx_en  in  1  loader enable; bytes arriving while it is low are ignored.
- uart_rx_valid  in  1  one-cycle strobe; uart_rx_data is valid.
- uart_rx_data  in  8  received byte.
- uart_rx_break  in  1  BREAK detected; restarts the loader.
- mem_we  out  1  one-cycle write strobe.
- mem_addr  out  ADDR_W  write address.
- mem_wdata  out  DATA_W  write data.
- write_done  out  1  sticky; load complete.
- overflow  out  1  sticky; a word arrived after DEPTH words were written.
- timeout_err  out  1  sticky; a partial word was discarded.
- word_count  out  ADDR_W+1  number of words written.
- checksum_ok  out  1  see Optional Feature.

Behaviour:
- Reset (resetn=0, async): all outputs 0 except checksum_ok=1; state IDLE; byte index 0; address 0.
- Byte acceptance: a byte is accepted when uart_rx_en=1, uart_rx_valid=1, and state is not DONE.
  - Byte k of a word lands in bits [8k+7:8k].
  - The byte index wraps from BPW-1 to 0, where BPW = DATA_W/8.
- States:
  - IDLE: byte index 0. On an accepted byte -> LOAD.
  - LOAD: partial word in progress.
  - When the final byte (index BPW-1) is accepted: if the word equals TERMINATOR -> DONE; otherwise -> IDLE and the word is written.
  - DONE: all bytes ignored; write_done=1. Exit only via reset or uart_rx_break.
- Write timing:
  - mem_we pulses for exactly 1 cycle, the cycle after the final byte's strobe.
  - mem_addr and mem_wdata are valid in the same cycle as the pulse.
  - The address and word_count increment on that pulse. The address saturates at DEPTH-1.
- Overflow: if a non-terminator word completes when word_count == DEPTH:
  - no mem_we is issued;
  - overflow=1 and write_done=1;
  - state -> DONE.
- Terminator arriving exactly when word_count == DEPTH is normal completion; overflow stays 0.
- Timeout:
  - The idle counter runs only in LOAD and clears on every accepted byte.
  - On reaching TIMEOUT_CYC: partial word discarded, byte index 0, timeout_err=1, state -> IDLE. Address is unchanged.
  - If a byte is accepted in the same cycle the counter would expire, the byte wins and there is no timeout.
- uart_rx_break (any state, synchronous):
  - address, byte index, word_count and all sticky flags are cleared; checksum_ok returns to 1;
  - state -> IDLE;
  - any pending mem_we in that cycle is suppressed.
  - If break and uart_rx_valid occur in the same cycle, the break wins and the byte is dropped.
- uart_rx_en low mid-word: the partial word is held; the timeout still runs.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- When defined:
  - After the terminator, the FSM enters state CSUM and assembles one further word.
  - That word is compared with the sum of all written words mod 2^DATA_W.
  - checksum_ok is then updated to the compare result and the FSM -> DONE.
  - write_done asserts only after the checksum word completes.
  - Timeout applies in CSUM: timeout_err=1, checksum_ok=0, state -> DONE.
  - On overflow the CSUM state is skipped.
- When not defined:
  - No CSUM state and no accumulator.
  - checksum_ok is tied to 1.

Decomposition:
- Package loader_pkg:
  - state enum {IDLE, LOAD, CSUM, DONE};
  - BYTE_W=8;
  - function default_terminator(DATA_W).
- Sub-module uart_byte_assembler:
  - contains the shift/insert register, byte index and timeout counter;
  - outputs word_valid, word and timeout_pulse.
- The top level holds the FSM, address/count, flags and checksum.

Test Plan:
1. DATA_W=32: send bytes 13 01 01 fe, then ff ff ff ff -> one mem_we at addr 0 with data 32'hfe010113; write_done=1 one cycle after the 8th strobe; word_count=1.
2. DEPTH=4: send 5 non-terminator words -> 4 writes to addr 0..3; the 5th is dropped; overflow=1; write_done=1; no mem_we after addr 3.
3. Send 2 bytes, then idle TIMEOUT_CYC clocks -> timeout_err=1, no write; then a full word 0x00000013 -> written at addr 0.
4. After write_done, pulse uart_rx_break, then send word 0xdeadbeef -> flags cleared; write at addr 0.
5. DATA_W=16: bytes 34 12 then ff ff -> write of 16'h1234 at addr 0; done.
6. LOADER_CHECKSUM_EN: words 1, 2, terminator, then 3 -> checksum_ok=1. Repeat with final word 4 -> checksum_ok=0. write_done=1 in both cases.
